// File: rtl/serial_7seg_receiver.sv
// rtl/serial_7seg_receiver.sv - shift-chain 7-segment frame receiver
// Optional segment decoder enabled by defining SEG_DECODE_EN.
module serial_7seg_receiver #(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_serial_clk,
  input  logic                    i_serial_data,
  input  logic                    i_serial_latch,
  output logic [8*NUM_DIGITS-1:0] o_segments,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_decode_err,
  output logic                    o_frame_stb,
  output logic                    o_frame_err,
  output logic                    o_busy
);

  localparam int FRAME_BITS = 8 * NUM_DIGITS;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_OVERRUN} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   latch_prev_q, latch_prev_d;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_shift;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]  seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]  dp_q, dp_d;
  logic [NUM_DIGITS-1:0]  derr_q, derr_d;
  logic                   stb_q, stb_d;
  logic                   ferr_q, ferr_d;

  logic                   sclk_s, data_s, latch_s;
  logic                   sclk_rise, latch_rise;
  logic [7:0]             byte_v;

`ifdef SEG_DECODE_EN
  // Returns {error, value}; dp bit is ignored by the caller.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7D:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h6F:   return 5'h09;
      7'h00:   return 5'h0A;
      default: return 5'h1F;
    endcase
  endfunction
`endif

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign latch_s = latch_sync_q[SYNC_STAGES-1];

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
    sclk_prev_d  = sclk_s;
    latch_prev_d = latch_s;
  end

  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_shift = cnt_q;
    shreg_d   = shreg_q;
    seg_d     = seg_q;
    digits_d  = digits_q;
    dp_d      = dp_q;
    derr_d    = derr_q;
    stb_d     = 1'b0;
    ferr_d    = 1'b0;
    byte_v    = '0;

    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      // Shift first so a coincident latch sees the updated count.
      if (sclk_rise) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], data_s};
        if (cnt_q != CNT_SAT) cnt_shift = cnt_q + 1'b1;
      end
      cnt_d = cnt_shift;

      if (latch_rise) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (cnt_shift == CNT_FULL) begin
          stb_d = 1'b1;
          seg_d = shreg_d;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            byte_v  = shreg_d[8*i +: 8];
            dp_d[i] = byte_v[7];
`ifdef SEG_DECODE_EN
            {derr_d[i], digits_d[4*i +: 4]} = seg_decode(byte_v[6:0]);
`endif
          end
        end else begin
          ferr_d = 1'b1;
        end
      end else if (sclk_rise) begin
        case (state_q)
          ST_IDLE:    state_d = ST_SHIFT;
          ST_SHIFT:   if (cnt_shift > CNT_FULL) state_d = ST_OVERRUN;
          ST_OVERRUN: state_d = ST_OVERRUN;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync_q  <= '0;
      data_sync_q  <= '0;
      latch_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      seg_q        <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      derr_q       <= '0;
      stb_q        <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      data_sync_q  <= data_sync_d;
      latch_sync_q <= latch_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      latch_prev_q <= latch_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      seg_q        <= seg_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      derr_q       <= derr_d;
      stb_q        <= stb_d;
      ferr_q       <= ferr_d;
    end
  end

  assign o_segments   = seg_q;
  assign o_digits     = digits_q;
  assign o_dp         = dp_q;
  assign o_decode_err = derr_q;
  assign o_frame_stb  = stb_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_7seg_receiver.sv
// tb/tb_serial_7seg_receiver.sv - randomized self-checking bench for serial_7seg_receiver
module tb_serial_7seg_receiver;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_en = 1'b1;
  logic        i_serial_clk = 1'b0;
  logic        i_serial_data = 1'b0;
  logic        i_serial_latch = 1'b0;
  logic [47:0] o_segments;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_decode_err;
  logic        o_frame_stb;
  logic        o_frame_err;
  logic        o_busy;

  serial_7seg_receiver #(.NUM_DIGITS(6), .SYNC_STAGES(2)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_serial_clk   (i_serial_clk),
    .i_serial_data  (i_serial_data),
    .i_serial_latch (i_serial_latch),
    .o_segments     (o_segments),
    .o_digits       (o_digits),
    .o_dp           (o_dp),
    .o_decode_err   (o_decode_err),
    .o_frame_stb    (o_frame_stb),
    .o_frame_err    (o_frame_err),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  int stb_cycles = 0;
  int err_cycles = 0;
  int busy_cycles = 0;

  always @(negedge i_clk) begin
    if (o_frame_stb) stb_cycles++;
    if (o_frame_err) err_cycles++;
    if (o_busy) busy_cycles++;
  end

  // Reference model: bits received since last frame boundary, plus expected outputs.
  bit          bits_q[$];
  logic [47:0] exp_seg = '0;
  logic [23:0] exp_dig = '0;
  logic [5:0]  exp_dp = '0;
  logic [5:0]  exp_derr = '0;
  int          exp_stb = 0;
  int          exp_err = 0;

  logic [7:0] digit_pats[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic model_decode(input logic [7:0] b, output logic [3:0] v, output logic e);
    v = 4'hF;
    e = 1'b1;
    if (b[6:0] == 7'h00) begin
      v = 4'hA;
      e = 1'b0;
    end
    for (int k = 0; k < 10; k++)
      if (b[6:0] == digit_pats[k][6:0]) begin
        v = 4'(k);
        e = 1'b0;
      end
  endtask

  task automatic model_latch();
    logic [7:0] b;
    logic [3:0] v;
    logic       e;
    if (!i_en) return;
    if (bits_q.size() == 48) begin
      for (int i = 0; i < 48; i++) exp_seg[47-i] = bits_q[i];
      for (int d = 0; d < 6; d++) begin
        b = exp_seg[47-8*d -: 8];
        model_decode(b, v, e);
        exp_dp[5-d] = b[7];
`ifdef SEG_DECODE_EN
        exp_dig[23-4*d -: 4] = v;
        exp_derr[5-d] = e;
`endif
      end
      exp_stb++;
    end else begin
      exp_err++;
    end
    bits_q.delete();
  endtask

  task automatic send_bit(input bit b);
    i_serial_data = b;
    wait_clks(4);
    i_serial_clk = 1'b1;
    if (i_en) bits_q.push_back(b);
    wait_clks(4);
    i_serial_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit((i < 48) ? f[47-i] : 1'($urandom));
  endtask

  task automatic do_latch();
    wait_clks(2);
    i_serial_latch = 1'b1;
    model_latch();
    wait_clks(3);
    i_serial_latch = 1'b0;
    wait_clks(8);
  endtask

  task automatic check_frame(input string tag, input int stb0, input int err0);
    check({tag, ".segments"}, 64'(o_segments), 64'(exp_seg));
    check({tag, ".digits"}, 64'(o_digits), 64'(exp_dig));
    check({tag, ".dp"}, 64'(o_dp), 64'(exp_dp));
    check({tag, ".decode_err"}, 64'(o_decode_err), 64'(exp_derr));
    check({tag, ".stb_cycles"}, 64'(stb_cycles - stb0), 64'(exp_stb));
    check({tag, ".err_cycles"}, 64'(err_cycles - err0), 64'(exp_err));
    check({tag, ".busy_idle"}, 64'(o_busy), 64'(0));
  endtask

  task automatic run_frame(input string tag, input logic [47:0] f, input int nbits);
    int s0, e0;
    s0 = stb_cycles;
    e0 = err_cycles;
    exp_stb = 0;
    exp_err = 0;
    send_frame(f, nbits);
    do_latch();
    check_frame(tag, s0, e0);
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(3) == 0) return 8'($urandom);
    return digit_pats[$urandom_range(9)] | {1'($urandom), 7'h00};
  endfunction

  initial begin
    int s0, e0, b0;
    logic [47:0] f;
    int nb;

    wait_clks(3);
    check("reset.segments", 64'(o_segments), 64'(0));
    check("reset.digits", 64'(o_digits), 64'(0));
    check("reset.flags", 64'({o_dp, o_decode_err, o_frame_stb, o_frame_err, o_busy}), 64'(0));
    i_reset = 1'b0;
    wait_clks(2);

    run_frame("empty_latch", '0, 0);
    run_frame("clock_123456", 48'h065B4FE66D7D, 48);
    run_frame("short_47", 48'h3F3F3F3F3F3F, 47);

    // Overrun: busy must hold after the 49th/50th bit until the latch
    s0 = stb_cycles;
    e0 = err_cycles;
    exp_stb = 0;
    exp_err = 0;
    send_frame(48'h7F7F7F7F7F7F, 50);
    wait_clks(6);
    check("overrun.busy", 64'(o_busy), 64'(1));
    do_latch();
    check_frame("overrun", s0, e0);

    run_frame("bad_digit2", 48'h06494F666D7D, 48);

    // Clock and latch edges arrive on the same cycle as the 48th bit
    s0 = stb_cycles;
    e0 = err_cycles;
    exp_stb = 0;
    exp_err = 0;
    f = 48'h6F7F07007D6D;
    send_frame(f, 47);
    i_serial_data = f[0];
    wait_clks(4);
    i_serial_clk = 1'b1;
    i_serial_latch = 1'b1;
    bits_q.push_back(f[0]);
    model_latch();
    wait_clks(3);
    i_serial_latch = 1'b0;
    wait_clks(1);
    i_serial_clk = 1'b0;
    wait_clks(8);
    check_frame("coincident", s0, e0);

    // Reset mid-frame discards the partial frame and clears outputs
    s0 = stb_cycles;
    e0 = err_cycles;
    send_frame(48'hFFFFFFFFFFFF, 20);
    #2 i_reset = 1'b1;
    bits_q.delete();
    exp_seg = '0;
    exp_dig = '0;
    exp_dp = '0;
    exp_derr = '0;
    @(negedge i_clk);
    check("midreset.segments", 64'(o_segments), 64'(0));
    check("midreset.flags", 64'({o_digits, o_dp, o_decode_err, o_frame_stb, o_frame_err, o_busy}), 64'(0));
    wait_clks(3);
    i_reset = 1'b0;
    wait_clks(2);
    exp_stb = 0;
    exp_err = 0;
    send_frame(48'h3F065B4F666D, 48);
    do_latch();
    check_frame("after_reset", s0, e0);

    // Receive disabled: nothing happens at all
    s0 = stb_cycles;
    e0 = err_cycles;
    b0 = busy_cycles;
    exp_stb = 0;
    exp_err = 0;
    i_en = 1'b0;
    send_frame(48'h7D7D7D7D7D7D, 48);
    do_latch();
    check("disabled.busy_cycles", 64'(busy_cycles - b0), 64'(0));
    check_frame("disabled", s0, e0);
    i_en = 1'b1;
    wait_clks(2);

    for (int it = 0; it < 10; it++) begin
      for (int d = 0; d < 6; d++) f[47-8*d -: 8] = rand_byte();
      case ($urandom_range(4))
        0:       nb = 46 + int'($urandom_range(1));
        1:       nb = 49 + int'($urandom_range(2));
        default: nb = 48;
      endcase
      run_frame($sformatf("rand%0d", it), f, nb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
